// File: rtl/duty_level_ctrl.sv
// Duty-level controller: two debounced push-buttons step a saturating 0..MAX_LEVEL
// level with auto-repeat while held; a synchronous load presets the level directly.
module duty_level_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned REPEAT_DELAY    = 8000,
    parameter int unsigned REPEAT_RATE     = 2000,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned RESET_LEVEL     = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_up_i,
    input  logic       btn_dn_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] duty_level_o,
    output logic       step_o,
    output logic       limit_o,
    output logic       btn_up_db_o,
    output logic       btn_dn_db_o
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_DELAY = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] TMR_RATE  = TMR_W'(REPEAT_RATE);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [3:0]       LVL_MAX   = 4'(MAX_LEVEL);
    localparam logic [3:0]       LVL_RST   = 4'(RESET_LEVEL);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD_UP = 2'd1;
    localparam logic [1:0] HOLD_DN = 2'd2;
    localparam logic [1:0] LOCK    = 2'd3;

    function automatic logic [3:0] clamp_level(input logic [3:0] v);
        return (v > LVL_MAX) ? LVL_MAX : v;
    endfunction

    function automatic logic at_bound(input logic [3:0] lvl, input logic dir_up);
        return dir_up ? (lvl >= LVL_MAX) : (lvl == 4'd0);
    endfunction

    function automatic logic [3:0] step_level(input logic [3:0] lvl, input logic dir_up);
        return dir_up ? (lvl + 4'd1) : (lvl - 4'd1);
    endfunction

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       db_q;
    logic [CNT_W-1:0] db_cnt [2];

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_nxt;
    logic             req_step;
    logic             req_up;
    logic [3:0]       level_q;

    // Stage p0/p1: two-flop synchroniser, then per-button debounce
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= {btn_dn_i, btn_up_i};
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != db_q[i]) begin
                    if (db_cnt[i] == DB_LIMIT) begin
                        db_q[i]   <= ~db_q[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A conflicting press always wins over a release so LOCK is entered
    // whenever both buttons are seen down together.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        req_step  = 1'b0;
        req_up    = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_q[0] && db_q[1]) begin
                    state_nxt = LOCK;
                end else if (db_q[0]) begin
                    state_nxt = HOLD_UP;
                    timer_nxt = TMR_DELAY;
                    req_step  = 1'b1;
                    req_up    = 1'b1;
                end else if (db_q[1]) begin
                    state_nxt = HOLD_DN;
                    timer_nxt = TMR_DELAY;
                    req_step  = 1'b1;
                end
            end
            HOLD_UP: begin
                if (db_q[1]) begin
                    state_nxt = LOCK;
                end else if (!db_q[0]) begin
                    state_nxt = IDLE;
                end else if (timer_q == TMR_ONE) begin
                    timer_nxt = TMR_RATE;
                    req_step  = 1'b1;
                    req_up    = 1'b1;
                end else begin
                    timer_nxt = timer_q - TMR_ONE;
                end
            end
            HOLD_DN: begin
                if (db_q[0]) begin
                    state_nxt = LOCK;
                end else if (!db_q[1]) begin
                    state_nxt = IDLE;
                end else if (timer_q == TMR_ONE) begin
                    timer_nxt = TMR_RATE;
                    req_step  = 1'b1;
                end else begin
                    timer_nxt = timer_q - TMR_ONE;
                end
            end
            LOCK: begin
                if (!db_q[0] && !db_q[1]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p2: FSM state, repeat timer and level register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            level_q <= LVL_RST;
            step_o  <= 1'b0;
            limit_o <= 1'b0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            step_o  <= 1'b0;
            limit_o <= 1'b0;
            if (load_i) begin
                level_q <= clamp_level(load_val_i);
            end else if (req_step) begin
                if (at_bound(level_q, req_up)) begin
                    limit_o <= 1'b1;
                end else begin
                    level_q <= step_level(level_q, req_up);
                    step_o  <= 1'b1;
                end
            end
        end
    end

    assign duty_level_o = level_q;
    assign btn_up_db_o  = db_q[0];
    assign btn_dn_db_o  = db_q[1];

endmodule

// File: tb/tb_duty_level_ctrl.sv
// Bench for duty_level_ctrl: directed scenarios plus random button/load traffic,
// every cycle compared against an event-level reference model.
module tb_duty_level_ctrl;

    localparam int DB    = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 5;
    localparam int MAXL  = 9;
    localparam int RSTL  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] duty_level;
    logic       step, limit, up_db, dn_db;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_step_seen = 0;
    int n_lim_seen = 0;

    // Reference model state
    bit   rq_up[$], rq_dn[$], win_up[$], win_dn[$];
    bit   m_db_up, m_db_dn;
    int   m_mode;   // 0 idle, 1 holding up, 2 holding down, 3 locked
    int   m_due;    // absolute cycle of the next auto-repeat step
    int   m_level;
    bit   m_step, m_limit;

    duty_level_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE),
        .MAX_LEVEL      (MAXL),
        .RESET_LEVEL    (RSTL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_up_i    (btn_up),
        .btn_dn_i    (btn_dn),
        .load_i      (load),
        .load_val_i  (load_val),
        .duty_level_o(duty_level),
        .step_o      (step),
        .limit_o     (limit),
        .btn_up_db_o (up_db),
        .btn_dn_db_o (dn_db)
    );

    always #5 clk = ~clk;

    function automatic bit all_differ(input bit q[$], input bit d);
        foreach (q[k]) if (q[k] == d) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int want;
        bit s;
        cyc++;
        if (rst) begin
            m_level = RSTL; m_step = 0; m_limit = 0;
            m_mode = 0; m_due = 0; m_db_up = 0; m_db_dn = 0;
            rq_up.delete(); rq_up.push_back(0); rq_up.push_back(0);
            rq_dn.delete(); rq_dn.push_back(0); rq_dn.push_back(0);
            win_up.delete(); win_dn.delete();
            return;
        end
        want = 0;
        case (m_mode)
            0: if (m_db_up && m_db_dn) m_mode = 3;
               else if (m_db_up) begin want = 1;  m_mode = 1; m_due = cyc + DELAY; end
               else if (m_db_dn) begin want = -1; m_mode = 2; m_due = cyc + DELAY; end
            1: if (m_db_dn) m_mode = 3;
               else if (!m_db_up) m_mode = 0;
               else if (cyc == m_due) begin want = 1; m_due = cyc + RATE; end
            2: if (m_db_up) m_mode = 3;
               else if (!m_db_dn) m_mode = 0;
               else if (cyc == m_due) begin want = -1; m_due = cyc + RATE; end
            default: if (!m_db_up && !m_db_dn) m_mode = 0;
        endcase
        m_step = 0; m_limit = 0;
        if (load) m_level = (int'(load_val) > MAXL) ? MAXL : int'(load_val);
        else if (want == 1) begin
            if (m_level == MAXL) m_limit = 1; else begin m_level++; m_step = 1; end
        end else if (want == -1) begin
            if (m_level == 0) m_limit = 1; else begin m_level--; m_step = 1; end
        end
        // Debounced state flips after DB+1 consecutive synchronised samples disagree with it.
        s = rq_up.pop_front(); rq_up.push_back(btn_up); win_up.push_back(s);
        if (win_up.size() > DB + 1) void'(win_up.pop_front());
        if (win_up.size() == DB + 1 && all_differ(win_up, m_db_up)) begin
            m_db_up = !m_db_up; win_up.delete();
        end
        s = rq_dn.pop_front(); rq_dn.push_back(btn_dn); win_dn.push_back(s);
        if (win_dn.size() > DB + 1) void'(win_dn.pop_front());
        if (win_dn.size() == DB + 1 && all_differ(win_dn, m_db_dn)) begin
            m_db_dn = !m_db_dn; win_dn.delete();
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (step)  n_step_seen++;
        if (limit) n_lim_seen++;
        check("model_level", {4'd0, duty_level}, 8'(m_level));
        check("model_step",  {7'd0, step},  {7'd0, m_step});
        check("model_limit", {7'd0, limit}, {7'd0, m_limit});
        check("model_up_db", {7'd0, up_db}, {7'd0, m_db_up});
        check("model_dn_db", {7'd0, dn_db}, {7'd0, m_db_dn});
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        int len;

        rst = 1'b1;
        repeat (2) tick();
        check("rst_level", {4'd0, duty_level}, 8'd0);
        check("rst_pulses", {6'd0, step, limit}, 8'd0);
        check("rst_db", {6'd0, up_db, dn_db}, 8'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Single press: debounced at t0+6, step at t0+7, no repeat inside the hold.
        btn_up = 1'b1;
        repeat (6) tick();
        check("press_db_early", {7'd0, up_db}, 8'd0);
        tick();
        check("press_db", {7'd0, up_db}, 8'd1);
        check("press_level_before", {4'd0, duty_level}, 8'd0);
        tick();
        check("press_level", {4'd0, duty_level}, 8'd1);
        check("press_step", {7'd0, step}, 8'd1);
        n_step_seen = 0;
        repeat (2) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        check("press_no_repeat", 8'(n_step_seen), 8'd0);

        // Glitch of three cycles is rejected.
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        n_step_seen = 0;
        repeat (10) tick();
        check("glitch_db", {7'd0, up_db}, 8'd0);
        check("glitch_level", {4'd0, duty_level}, 8'd1);
        check("glitch_steps", 8'(n_step_seen), 8'd0);

        // Auto-repeat into saturation.
        do_load(4'd7);
        n_step_seen = 0; n_lim_seen = 0;
        btn_up = 1'b1;
        repeat (40) tick();
        check("repeat_level", {4'd0, duty_level}, 8'd9);
        check("repeat_steps", 8'(n_step_seen), 8'd2);
        check("repeat_limits", 8'(n_lim_seen), 8'd2);
        btn_up = 1'b0;
        repeat (10) tick();

        // Down at zero.
        do_load(4'd0);
        btn_dn = 1'b1;
        repeat (8) tick();
        check("dnsat_limit", {7'd0, limit}, 8'd1);
        check("dnsat_step", {7'd0, step}, 8'd0);
        check("dnsat_level", {4'd0, duty_level}, 8'd0);
        tick();
        btn_dn = 1'b0;
        repeat (10) tick();

        // Conflict handling.
        do_load(4'd5);
        btn_up = 1'b1;
        repeat (10) tick();
        btn_dn = 1'b1;
        repeat (15) tick();
        check("lock_level", {4'd0, duty_level}, 8'd6);
        btn_up = 1'b0;
        n_step_seen = 0; n_lim_seen = 0;
        repeat (15) tick();
        check("lock_one_held", 8'(n_step_seen + n_lim_seen), 8'd0);
        btn_dn = 1'b0;
        repeat (10) tick();
        btn_dn = 1'b1;
        repeat (10) tick();
        check("unlock_down", {4'd0, duty_level}, 8'd5);
        btn_dn = 1'b0;
        repeat (10) tick();

        // Load clamp, and load colliding with a step.
        do_load(4'd12);
        check("load_clamp", {4'd0, duty_level}, 8'd9);
        do_load(4'd6);
        btn_up = 1'b1;
        repeat (7) tick();
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        check("load_prio_level", {4'd0, duty_level}, 8'd3);
        check("load_prio_pulses", {6'd0, step, limit}, 8'd0);
        repeat (4) tick();
        btn_up = 1'b0;
        repeat (10) tick();

        // Reset during HOLD_UP with the button kept down.
        do_load(4'd4);
        btn_up = 1'b1;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check("midrst_level", {4'd0, duty_level}, 8'd0);
        check("midrst_db", {7'd0, up_db}, 8'd0);
        tick();
        rst = 1'b0;
        repeat (7) tick();
        check("postrst_wait", {4'd0, duty_level}, 8'd0);
        tick();
        check("postrst_level", {4'd0, duty_level}, 8'd1);
        check("postrst_step", {7'd0, step}, 8'd1);
        btn_up = 1'b0;
        repeat (10) tick();

        // Random traffic against the model.
        for (int seg = 0; seg < 160; seg++) begin
            r = 4'($urandom_range(0, 15));
            btn_up = r[0];
            btn_dn = r[1] & r[2];
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                load = ($urandom_range(0, 19) == 0);
                load_val = 4'($urandom_range(0, 15));
                rst = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        load = 1'b0; rst = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
